// File: rtl/seq_pattern_detector.sv
// Serial pattern detector with saturating match counter.
// Define SEQ_DET_MOORE_OUT_EN for a registered (Moore) yout; default is combinational (Mealy).
module seq_pattern_detector #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 OVERLAP = 1,
  parameter int                 CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ain,
  input  logic             ain_valid,
  input  logic             clr_cnt,
  output logic             yout,
  output logic [CNT_W-1:0] count
);

  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

  logic [PAT_LEN-1:0] hist;
  logic [PAT_LEN-1:0] nh;
  logic [FW-1:0]      fill;
  logic [FW-1:0]      nf;
  logic               match;

  always_comb begin
    nh    = {hist[PAT_LEN-2:0], ain};
    nf    = (fill == FULL) ? FULL : fill + 1'b1;
    match = ain_valid && (nf == FULL) && (nh == PATTERN);
  end

  // Idle cycles hold history and fill, so gaps never break a partial sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= '0;
      fill <= '0;
    end else if (ain_valid) begin
      hist <= nh;
      if (match) fill <= (OVERLAP != 0) ? FULL : '0;
      else       fill <= nf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                       count <= '0;
    else if (clr_cnt)                count <= '0;
    else if (match && (count != '1)) count <= count + 1'b1;
  end

`ifdef SEQ_DET_MOORE_OUT_EN
  logic yout_q;

  always_ff @(posedge clk) begin
    if (reset) yout_q <= 1'b0;
    else       yout_q <= match;
  end

  assign yout = yout_q;
`else
  assign yout = match & ~reset;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench: three detector instances (overlap, non-overlap, 2-bit counter) share one stimulus stream.
module tb_seq_pattern_detector;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       ain       = 1'b0;
  logic       ain_valid = 1'b0;
  logic       clr_cnt   = 1'b0;
  logic       yout0, yout1, yout2;
  logic [3:0] count0, count1;
  logic [1:0] count2;
  logic       y0, y1, y2;
  logic [3:0] pat = 4'b1011;
  logic [6:0] strm = 7'b1011011;
  logic [6:0] ey0  = 7'b0001001;
  logic [6:0] ey1  = 7'b0001000;
  int         ec0[7] = '{0, 0, 0, 1, 1, 1, 2};
  int         ec1[7] = '{0, 0, 0, 1, 1, 1, 1};
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  seq_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .ain(ain), .ain_valid(ain_valid), .clr_cnt(clr_cnt),
    .yout(yout0), .count(count0));

  seq_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .ain(ain), .ain_valid(ain_valid), .clr_cnt(clr_cnt),
    .yout(yout1), .count(count1));

  seq_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .ain(ain), .ain_valid(ain_valid), .clr_cnt(clr_cnt),
    .yout(yout2), .count(count2));

  // One clock per call; y* is the pulse attributed to this bit, count* is post-edge.
  task automatic step(input logic r, input logic a, input logic v, input logic c);
    reset = r; ain = a; ain_valid = v; clr_cnt = c;
    @(negedge clk);
`ifndef SEQ_DET_MOORE_OUT_EN
    y0 = yout0; y1 = yout1; y2 = yout2;
`endif
    @(posedge clk);
    #1;
`ifdef SEQ_DET_MOORE_OUT_EN
    y0 = yout0; y1 = yout1; y2 = yout2;
`endif
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset held two cycles with ain=1
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("rst_y0", 32'(y0), 0);
      chk("rst_cnt0", 32'(count0), 0);
    end

    // stream 1011011, overlap vs non-overlap (first bit is the cycle after release)
    for (int i = 0; i < 7; i++) begin
      step(1'b0, strm[6-i], 1'b1, 1'b0);
      chk("strm_y0", 32'(y0), 32'(ey0[6-i]));
      chk("strm_y1", 32'(y1), 32'(ey1[6-i]));
      chk("strm_cnt0", 32'(count0), ec0[i]);
      chk("strm_cnt1", 32'(count1), ec1[i]);
    end
    chk("strm_cnt2", 32'(count2), 1);

    // 1011 with three idle cycles (ain toggling) before each bit
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("gap_rst_cnt0", 32'(count0), 0);
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < 3; g++) begin
        step(1'b0, ~g[0], 1'b0, 1'b0);
        chk("gap_idle_y0", 32'(y0), 0);
      end
      step(1'b0, pat[3-b], 1'b1, 1'b0);
      chk("gap_bit_y0", 32'(y0), 32'(b == 3));
      chk("gap_bit_y1", 32'(y1), 32'(b == 3));
    end
    chk("gap_cnt0", 32'(count0), 1);
    chk("gap_cnt1", 32'(count1), 1);

    // five matches: 2-bit counter saturates at 3, 4-bit counter keeps counting
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int m = 0; m < 5; m++) begin
      for (int b = 0; b < 4; b++) begin
        step(1'b0, pat[3-b], 1'b1, 1'b0);
        chk("sat_y2", 32'(y2), 32'(b == 3));
      end
      chk("sat_cnt2", 32'(count2), (m + 1 > 3) ? 3 : m + 1);
      chk("sat_cnt0", 32'(count0), m + 1);
    end

    // clr_cnt coincident with the 3rd match
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int m = 0; m < 3; m++) begin
      for (int b = 0; b < 4; b++) begin
        step(1'b0, pat[3-b], 1'b1, 1'(m == 2 && b == 3));
      end
      chk("clr_y0", 32'(y0), 1);
      chk("clr_y1", 32'(y1), 1);
      chk("clr_cnt0", 32'(count0), (m == 2) ? 0 : m + 1);
      chk("clr_cnt2", 32'(count2), (m == 2) ? 0 : m + 1);
    end

    // partial prefix 1,0,1 then reset (ain=1 would complete 1011 if consumed)
    for (int b = 0; b < 3; b++) begin
      step(1'b0, pat[3-b], 1'b1, 1'b0);
      chk("pre_y0", 32'(y0), 0);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("mid_rst_y0", 32'(y0), 0);
    chk("mid_rst_y1", 32'(y1), 0);
    chk("mid_rst_cnt0", 32'(count0), 0);
    for (int b = 0; b < 4; b++) begin
      step(1'b0, pat[3-b], 1'b1, 1'b0);
      chk("post_y0", 32'(y0), 32'(b == 3));
      chk("post_y1", 32'(y1), 32'(b == 3));
    end
    chk("post_cnt0", 32'(count0), 1);
    chk("post_cnt1", 32'(count1), 1);
    chk("post_cnt2", 32'(count2), 1);

    // idle cycle after a match: yout must not stretch
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("idle_y0", 32'(y0), 0);
    chk("idle_cnt0", 32'(count0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised serial pattern detector with a saturating match counter. It samples one bit per qualified clock from `ain`, compares the most recent `PAT_LEN` bits against a compile-time `PATTERN`, and pulses `yout` on each match. Overlapping or non-overlapping detection is selected per instance. It generalises the fixed-pattern 4-bit-count sequence detector in the lab datapath, adding arbitrary pattern length and value, a sample qualifier and a counter clear.

## Interface
- `PAT_LEN`, default 4: pattern length in bits; legal range 2..32.
- `PATTERN`, default 4'b1011: `PAT_LEN`-bit pattern; the MSB is the first bit received.
- `OVERLAP`, default 1: 1 = overlapping detection; 0 = history discarded after each match.
- `CNT_W`, default 4: match counter width; legal range ≥1.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ain`  in  1  serial data bit.
- `ain_valid`  in  1  qualifies `ain`; the bit is consumed only when high.
- `clr_cnt`  in  1  synchronous clear of `count`.
- `yout`  out  1  match pulse.
- `count`  out  `CNT_W`  number of matches since reset or the last clear, saturating.

## Operation
- State:
  - `hist[PAT_LEN-1:0]`: shift history.
  - `fill`: number of valid history bits, 0..`PAT_LEN`, `$clog2(PAT_LEN+1)` bits wide.
  - `count`.
  - Registered `yout`, Moore build only.
- Valid cycle (`ain_valid`=1):
  - `nh = {hist[PAT_LEN-2:0], ain}`.
  - `nf = min(fill+1, PAT_LEN)`.
  - `match = (nf == PAT_LEN) && (nh == PATTERN)`.
  - `hist <= nh`.
- Fill update:
  - No match: `fill <= nf`.
  - Match with `OVERLAP`=1: `fill <= PAT_LEN`, so the history suffix can start the next match.
  - Match with `OVERLAP`=0: `fill <= 0`; `hist` contents are then don't-care.
- Idle cycle (`ain_valid`=0): `hist` and `fill` hold; `match`=0; gaps never break a partial sequence.
- Counter:
  - `count <= count+1` on `match`.
  - Saturates at 2^`CNT_W`-1 and never wraps.
- Priority, highest first: `reset` > `clr_cnt` > increment.
  - `clr_cnt` with a simultaneous match leaves `count`=0.
  - The match is still reported on `yout`.
- Reset mid-stream: `fill`=0, so any partial prefix is discarded; the next match needs `PAT_LEN` fresh valid bits.
- Reset values: `hist`=0, `fill`=0, `count`=0, `yout`=0.

## Timing
- Mealy build (default):
  - `yout = match & ~reset`, combinational.
  - High in the same cycle the final pattern bit is presented with `ain_valid`.
- Moore build: `yout` is registered and high for exactly one cycle after the edge that consumed the final bit.
- `count` reflects a match from the cycle after the consuming edge in both builds.
- Back-to-back matches are possible only with `OVERLAP`=1 and a self-overlapping `PATTERN`.
  - In that case `yout` may be high on consecutive valid cycles.
  - `yout` is never stretched by idle cycles.
- Minimum spacing between matches with `OVERLAP`=0: `PAT_LEN` valid bits.

## Configuration
- Macro: `SEQ_DET_MOORE_OUT_EN`.
- Defined: `yout` is registered (Moore); one cycle latency after the final bit; glitch-free.
- Undefined: `yout` is combinational (Mealy); zero latency.
- `count`, `hist` and `fill` behaviour are identical in both builds.

## Test plan
All scenarios use `PAT_LEN`=4, `PATTERN`=4'b1011, `CNT_W`=4 unless stated; `ain_valid`=1 unless stated.
1. Hold `reset` for 2 cycles with `ain`=1 -> `yout`=0 and `count`=0 throughout and in the cycle after release.
2. `OVERLAP`=1, stream 1,0,1,1,0,1,1 -> `yout` pulses on bits 4 and 7 (Mealy: same cycle; Moore: +1 cycle); final `count`=2.
3. `OVERLAP`=0, same stream -> single pulse on bit 4; final `count`=1.
4. Stream 1,0,1,1 with `ain_valid`=0 for 3 cycles between each bit and `ain` toggling during the gaps -> exactly one pulse, `count`=1.
5. `CNT_W`=2, 5 non-overlapping matches -> `count` 1,2,3,3,3; `yout` pulses 5 times.
6. Assert `clr_cnt` in the cycle of the 3rd match -> `yout` pulses and `count` reads 0 next cycle. Then assert `reset` after bits 1,0,1 of the next pattern, and send 1,0,1,1 -> no match until the 4th bit after reset; `count`=1.
